// File: rtl/fft_ctrl_pkg.sv
// Shared types, constants and helpers for the FFT frame sequencer / peak picker.
package fft_ctrl_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int MAG_W     = BIT_WIDTH + 1;

  localparam logic signed [BIT_WIDTH-1:0] MOST_NEG = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SCAN   = 3'd4,
    ST_REPORT = 3'd5
  } fft_ctrl_state_t;

  // Absolute value of a signed component, widened by one bit. The most
  // negative code has no positive twin, so it saturates to the largest
  // positive one instead of wrapping.
  function automatic logic [MAG_W-1:0] sat_abs(input logic signed [BIT_WIDTH-1:0] v);
    logic [MAG_W-1:0] r;
    if (v == MOST_NEG) begin
      r = {2'b00, {(BIT_WIDTH-1){1'b1}}};
    end else if (v[BIT_WIDTH-1]) begin
      r = {1'b0, -v};
    end else begin
      r = {1'b0, v};
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_peak_tracker.sv
// Running argmax over |re|+|im| of the FFT bins presented one per cycle.
// Ties keep the earlier (lower) bin because only a strictly larger
// magnitude replaces the stored peak.
module fft_peak_tracker
  import fft_ctrl_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH,
  parameter int M         = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   valid,
  input  logic [M-1:0]           bin,
  input  logic [2*bit_width-1:0] wd,
  output logic [M-1:0]           peak_bin,
  output logic [bit_width:0]     peak_mag
);

  logic signed [bit_width-1:0] re;
  logic signed [bit_width-1:0] im;
  logic [bit_width:0]          mag;

  assign re  = wd[2*bit_width-1:bit_width];
  assign im  = wd[bit_width-1:0];
  // Both terms are at most 2^(bit_width-1)-1, so the sum cannot overflow.
  assign mag = sat_abs(re) + sat_abs(im);

  // Clear at the start of a scan, then keep the first strictly-largest bin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_bin <= '0;
      peak_mag <= '0;
    end else if (clear) begin
      peak_bin <= '0;
      peak_mag <= '0;
    end else if (valid && (mag > peak_mag)) begin
      peak_bin <= bin;
      peak_mag <= mag;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer and peak picker in front of fft_top: loads N real samples,
// starts the transform, waits for done, scans bins 1..N/2-1 for the largest
// |re|+|im| and reports it, repeating while enable is high.
// Optional build macro FFT_CTRL_TIMEOUT_EN adds a bounded wait for fft_done
// with a sticky timeout_err flag; without it the wait is unbounded.
//
// Sample handshake: a sample transfers in a cycle where s_valid && s_ready.
// s_ready is high exactly while in LOAD and does not depend on s_valid;
// s_valid is ignored in every other state.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH,
  parameter int M         = 9,
  parameter int N         = 512,
  parameter int TIMEOUT   = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [bit_width-1:0]   s_data,
  output logic                   fft_load,
  output logic [M-1:0]           fft_adr,
  output logic [2*bit_width-1:0] fft_rd,
  output logic                   fft_start,
  input  logic                   fft_done,
  input  logic [2*bit_width-1:0] fft_wd,
  output logic                   peak_valid,
  output logic [M-1:0]           peak_bin,
  output logic [bit_width:0]     peak_mag,
  output logic                   busy,
  output logic                   timeout_err,
  output fft_ctrl_state_t        dbg_state
);

  localparam logic [M-1:0] LAST_SAMPLE = M'(N - 1);
  // Scan address that marks "all bins issued"; it is never put on fft_adr.
  localparam logic [M-1:0] SCAN_END    = M'(N / 2);

  fft_ctrl_state_t    state;
  logic [M-1:0]       load_cnt;
  logic [M-1:0]       scan_adr;
  logic               scan_issue;
  logic               cmp_valid;
  logic [M-1:0]       cmp_bin;
  logic               peak_clear;
  logic [M-1:0]       trk_bin;
  logic [bit_width:0] trk_mag;
  logic [M-1:0]       held_bin;
  logic [bit_width:0] held_mag;

`ifdef FFT_CTRL_TIMEOUT_EN
  logic [31:0]        wait_cnt;
`endif

  assign dbg_state  = state;
  assign scan_issue = (state == ST_SCAN) && (scan_adr != SCAN_END);
  assign peak_clear = (state == ST_WAIT) && fft_done;

  // Sample write path is combinational so the RAM sees the sample in the
  // same cycle as the handshake.
  assign fft_load = (state == ST_LOAD) && s_valid && s_ready;
  assign fft_rd   = fft_load ? {s_data, {bit_width{1'b0}}} : '0;

  // Shared address bus: load address while loading, bin address while scanning.
  always_comb begin
    fft_adr = '0;
    if (state == ST_LOAD) begin
      fft_adr = load_cnt;
    end else if (scan_issue) begin
      fft_adr = scan_adr;
    end
  end

  // Frame sequencing FSM with its registered outputs and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      s_ready    <= 1'b0;
      fft_start  <= 1'b0;
      peak_valid <= 1'b0;
      busy       <= 1'b0;
      load_cnt   <= '0;
      scan_adr   <= '0;
`ifdef FFT_CTRL_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      fft_start  <= 1'b0;
      peak_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state    <= ST_LOAD;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
            load_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (s_valid && s_ready) begin
            load_cnt <= load_cnt + M'(1);
            if (load_cnt == LAST_SAMPLE) begin
              state     <= ST_START;
              s_ready   <= 1'b0;
              fft_start <= 1'b1;
            end
          end
        end
        ST_START: begin
          // fft_done seen here belongs to no transform we started; ignore it.
          state <= ST_WAIT;
`ifdef FFT_CTRL_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (fft_done) begin
            state    <= ST_SCAN;
            scan_adr <= M'(1);
          end
`ifdef FFT_CTRL_TIMEOUT_EN
          else if (wait_cnt == 32'(TIMEOUT - 1)) begin
            // Abandon this frame and reload; no result is reported for it.
            state       <= ST_LOAD;
            s_ready     <= 1'b1;
            load_cnt    <= '0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end
        ST_SCAN: begin
          // The cycle with scan_adr == SCAN_END only waits for the last read.
          if (scan_adr == SCAN_END) begin
            state      <= ST_REPORT;
            peak_valid <= 1'b1;
          end else begin
            scan_adr <= scan_adr + M'(1);
          end
        end
        ST_REPORT: begin
          if (enable) begin
            state    <= ST_LOAD;
            s_ready  <= 1'b1;
            load_cnt <= '0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifndef FFT_CTRL_TIMEOUT_EN
  // Without the bounded wait the flag can never set; TIMEOUT has no effect.
  assign timeout_err = 1'b0 && (TIMEOUT != 0);
`endif

  // Read data returns one cycle after its address; delay the bin tag to match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmp_valid <= 1'b0;
      cmp_bin   <= '0;
    end else begin
      cmp_valid <= scan_issue;
      cmp_bin   <= scan_adr;
    end
  end

  fft_peak_tracker #(
    .bit_width (bit_width),
    .M         (M)
  ) u_peak (
    .clk      (clk),
    .reset    (reset),
    .clear    (peak_clear),
    .valid    (cmp_valid),
    .bin      (cmp_bin),
    .wd       (fft_wd),
    .peak_bin (trk_bin),
    .peak_mag (trk_mag)
  );

  // Keep the last reported result stable while the next frame is scanned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_bin <= '0;
      held_mag <= '0;
    end else if (state == ST_REPORT) begin
      held_bin <= trk_bin;
      held_mag <= trk_mag;
    end
  end

  assign peak_bin = (state == ST_REPORT) ? trk_bin : held_bin;
  assign peak_mag = (state == ST_REPORT) ? trk_mag : held_mag;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a behavioural fft_top stand-in.
module tb_fft_frame_ctrl;
  import fft_ctrl_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            s_valid;
  logic            s_ready;
  logic [15:0]     s_data;
  logic            fft_load;
  logic [8:0]      fft_adr;
  logic [31:0]     fft_rd;
  logic            fft_start;
  logic            fft_done;
  logic [31:0]     fft_wd;
  logic            peak_valid;
  logic [8:0]      peak_bin;
  logic [16:0]     peak_mag;
  logic            busy;
  logic            timeout_err;
  fft_ctrl_state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  // Event counters sampled on the falling edge.
  int start_hi = 0;
  int load_hi  = 0;
  int pv_hi    = 0;
  int to_hi    = 0;

  logic [15:0] spec_re [512];
  logic [15:0] spec_im [512];

  fft_frame_ctrl #(
    .bit_width (16),
    .M         (9),
    .N         (512),
    .TIMEOUT   (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .fft_load    (fft_load),
    .fft_adr     (fft_adr),
    .fft_rd      (fft_rd),
    .fft_start   (fft_start),
    .fft_done    (fft_done),
    .fft_wd      (fft_wd),
    .peak_valid  (peak_valid),
    .peak_bin    (peak_bin),
    .peak_mag    (peak_mag),
    .busy        (busy),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // FFT RAM read port: data one cycle after address.
  always @(posedge clk) fft_wd <= {spec_re[fft_adr], spec_im[fft_adr]};

  always @(negedge clk) begin
    if (fft_start === 1'b1) start_hi++;
    if (fft_load === 1'b1) load_hi++;
    if (peak_valid === 1'b1) pv_hi++;
    if (timeout_err === 1'b1) to_hi++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_spec();
    for (int b = 0; b < 512; b++) begin
      spec_re[b] = 16'h0000;
      spec_im[b] = 16'h0000;
    end
  endtask

  // Waits for s_ready (bounded), then streams `count` samples 0..count-1.
  // Returns at 1 ns after the edge following the last handshake.
  task automatic feed_frame(input int count, output int load_bad, output int ready_wait);
    int n;
    n = 0;
    while (s_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ready_wait = n;
    load_bad = 0;
    for (int i = 0; i < count; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(i);
      #1;
      if (fft_load !== 1'b1 || fft_adr !== 9'(i) || fft_rd !== {16'(i), 16'h0000}) load_bad++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  // Called in the start-pulse cycle. Raises fft_done t_fft cycles later and
  // watches 300 cycles after it: lat is the cycle offset of peak_valid.
  task automatic finish_frame(input int t_fft, input bit early_done,
                              output int lat, output int pv_cnt,
                              output logic [8:0] bin, output logic [16:0] mag);
    if (early_done) fft_done = 1'b1;
    for (int k = 0; k < t_fft; k++) begin
      @(posedge clk); #1;
      fft_done = 1'b0;
    end
    fft_done = 1'b1;
    @(posedge clk); #1;
    fft_done = 1'b0;
    lat = -1; pv_cnt = 0; bin = '0; mag = '0;
    for (int k = 1; k <= 300; k++) begin
      if (peak_valid === 1'b1) begin
        pv_cnt++;
        if (lat < 0) begin
          lat = k; bin = peak_bin; mag = peak_mag;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int load_bad, ready_wait, s0;
    reset = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0; fft_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b0 || fft_load !== 1'b0 || fft_start !== 1'b0 || peak_valid !== 1'b0 ||
        busy !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got rdy=%b ld=%b st=%b pv=%b busy=%b to=%b expected all 0",
               s_ready, fft_load, fft_start, peak_valid, busy, timeout_err);
    end
    checks++;
    if (fft_adr !== 9'd0 || fft_rd !== 32'd0 || peak_bin !== 9'd0 || peak_mag !== 17'd0) begin
      failures++;
      $display("FAIL reset_data: got adr=%0d rd=%h bin=%0d mag=%0d expected 0", fft_adr, fft_rd, peak_bin, peak_mag);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    // Enabled load interrupted by reset after 200 samples.
    s0 = start_hi;
    enable = 1'b1;
    feed_frame(200, load_bad, ready_wait);
    checks++;
    if (load_bad !== 0 || ready_wait >= 20) begin
      failures++;
      $display("FAIL partial_load: got bad=%0d wait=%0d expected 0 and <20", load_bad, ready_wait);
    end
    s_valid = 1'b1; s_data = 16'd200;
    reset = 1'b0;
    #1;
    checks++;
    if (fft_load !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0 || fft_adr !== 9'd0 ||
        fft_rd !== 32'd0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL midload_reset: got ld=%b rdy=%b busy=%b adr=%0d rd=%h st=%0d expected 0/IDLE",
               fft_load, s_ready, busy, fft_adr, fft_rd, dbg_state);
    end
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    // s_valid still high while idle must be ignored.
    checks++;
    if (fft_load !== 1'b0 || s_ready !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL idle_ignore: got ld=%b rdy=%b st=%0d expected 0 0 IDLE", fft_load, s_ready, dbg_state);
    end
    checks++;
    if (start_hi - s0 !== 0) begin
      failures++;
      $display("FAIL reset_no_start: got %0d start cycles expected 0", start_hi - s0);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_load_and_peak();
    int load_bad, ready_wait, l0, s0, lat, pvc;
    logic [8:0] bin; logic [16:0] mag;
    for (int b = 0; b < 512; b++) begin
      spec_re[b] = 16'((b % 11) - 5);
      spec_im[b] = 16'(5 - (b % 7));
    end
    spec_re[10] = 16'd1000; spec_im[10] = 16'd0;
    enable = 1'b1;
    l0 = load_hi; s0 = start_hi;
    feed_frame(512, load_bad, ready_wait);
    checks++;
    if (load_bad !== 0 || ready_wait >= 20) begin
      failures++;
      $display("FAIL load_addr: got bad=%0d wait=%0d expected 0 and <20", load_bad, ready_wait);
    end
    checks++;
    if (load_hi - l0 !== 512) begin
      failures++;
      $display("FAIL load_cycles: got %0d expected 512", load_hi - l0);
    end
    checks++;
    if (fft_start !== 1'b1 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL start_pulse: got start=%b rdy=%b expected 1 0", fft_start, s_ready);
    end
    // A done coinciding with start must be ignored.
    finish_frame(20, 1'b1, lat, pvc, bin, mag);
    checks++;
    if (start_hi - s0 !== 1) begin
      failures++;
      $display("FAIL start_once: got %0d cycles expected 1", start_hi - s0);
    end
    checks++;
    if (lat !== 257 || pvc !== 1) begin
      failures++;
      $display("FAIL peak_timing: got lat=%0d count=%0d expected 257 1", lat, pvc);
    end
    checks++;
    if (bin !== 9'd10 || mag !== 17'd1000) begin
      failures++;
      $display("FAIL peak_main: got bin=%0d mag=%0d expected 10 1000", bin, mag);
    end
    checks++;
    if (peak_bin !== 9'd10 || peak_mag !== 17'd1000 || dbg_state !== ST_LOAD || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL peak_hold: got bin=%0d mag=%0d st=%0d rdy=%b expected 10 1000 LOAD 1",
               peak_bin, peak_mag, dbg_state, s_ready);
    end
  endtask

  task automatic test_ties_and_saturation();
    int load_bad, ready_wait, lat, pvc;
    logic [8:0] bin; logic [16:0] mag;
    clear_spec();
    spec_re[12] = 16'd700;
    spec_im[40] = 16'(-700);
    feed_frame(512, load_bad, ready_wait);
    finish_frame(5, 1'b0, lat, pvc, bin, mag);
    checks++;
    if (bin !== 9'd12 || mag !== 17'd700 || lat !== 257) begin
      failures++;
      $display("FAIL peak_tie: got bin=%0d mag=%0d lat=%0d expected 12 700 257", bin, mag, lat);
    end
    clear_spec();
    spec_re[5] = 16'h8000;
    feed_frame(512, load_bad, ready_wait);
    finish_frame(3, 1'b0, lat, pvc, bin, mag);
    checks++;
    if (bin !== 9'd5 || mag !== 17'd32767) begin
      failures++;
      $display("FAIL peak_sat: got bin=%0d mag=%0d expected 5 32767", bin, mag);
    end
    clear_spec();
    spec_re[1]   = 16'd299;
    spec_re[255] = 16'd300;
    spec_re[256] = 16'd5000;
    feed_frame(512, load_bad, ready_wait);
    finish_frame(7, 1'b0, lat, pvc, bin, mag);
    checks++;
    if (bin !== 9'd255 || mag !== 17'd300) begin
      failures++;
      $display("FAIL peak_last_bin: got bin=%0d mag=%0d expected 255 300", bin, mag);
    end
  endtask

  task automatic test_unscanned_and_disable();
    int load_bad, ready_wait, lat, pvc;
    logic [8:0] bin; logic [16:0] mag;
    clear_spec();
    spec_re[0]   = 16'd30000;
    spec_re[300] = 16'(-30000);
    feed_frame(512, load_bad, ready_wait);
    // Dropping enable mid-frame still completes this frame, then idles.
    enable = 1'b0;
    finish_frame(10, 1'b0, lat, pvc, bin, mag);
    checks++;
    if (bin !== 9'd0 || mag !== 17'd0 || pvc !== 1) begin
      failures++;
      $display("FAIL peak_unscanned: got bin=%0d mag=%0d count=%0d expected 0 0 1", bin, mag, pvc);
    end
    checks++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL disable_idle: got st=%0d busy=%b rdy=%b expected IDLE 0 0", dbg_state, busy, s_ready);
    end
    enable = 1'b1;
  endtask

  task automatic test_timeout();
    int load_bad, ready_wait, lat, pvc, p0, t0, n;
    logic [8:0] bin; logic [16:0] mag;
    clear_spec();
    spec_im[77] = 16'd1234;
    p0 = pv_hi; t0 = to_hi;
    feed_frame(512, load_bad, ready_wait);
`ifdef FFT_CTRL_TIMEOUT_EN
    n = 0;
    while (timeout_err !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 101 || s_ready !== 1'b1 || dbg_state !== ST_LOAD) begin
      failures++;
      $display("FAIL timeout_fire: got cycles=%0d rdy=%b st=%0d expected 101 1 LOAD", n, s_ready, dbg_state);
    end
    checks++;
    if (pv_hi - p0 !== 0) begin
      failures++;
      $display("FAIL timeout_no_peak: got %0d expected 0", pv_hi - p0);
    end
    feed_frame(512, load_bad, ready_wait);
    finish_frame(10, 1'b0, lat, pvc, bin, mag);
    checks++;
    if (timeout_err !== 1'b1 || bin !== 9'd77 || mag !== 17'd1234) begin
      failures++;
      $display("FAIL timeout_sticky: got to=%b bin=%0d mag=%0d expected 1 77 1234", timeout_err, bin, mag);
    end
`else
    n = 0;
    finish_frame(150, 1'b0, lat, pvc, bin, mag);
    checks++;
    if (to_hi - t0 !== n || lat !== 257 || pvc !== 1) begin
      failures++;
      $display("FAIL long_wait: got to_cycles=%0d lat=%0d count=%0d expected 0 257 1", to_hi - t0, lat, pvc);
    end
    checks++;
    if (bin !== 9'd77 || mag !== 17'd1234 || pv_hi - p0 !== 1) begin
      failures++;
      $display("FAIL long_wait_peak: got bin=%0d mag=%0d pulses=%0d expected 77 1234 1", bin, mag, pv_hi - p0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_and_peak();
    test_ties_and_saturation();
    test_unscanned_and_disable();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
